// File: rtl/aclk_controller.sv
// -----------------------------------------------------------------------------
// aclk_controller
//   Key-entry and display-select controller for an alarm clock. It collects
//   up to four keypad digits into a shift buffer (HH:MM). It then loads them
//   into the time counter (time_button) or the alarm register (alarm_button).
//   Key entry is abandoned after TIMEOUT_SEC one_second pulses without a key.
//
//   Optional feature: define ACLK_KEY_VALIDATE_EN to reject buffers that are
//   not a legal 24h time. A rejected buffer raises o_key_error for one cycle
//   and causes no load. With the macro undefined, o_key_error is tied to 0.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   i_one_second     one-cycle pulse, once per second
//   i_key            keypad code: 0..9 digit, 4'hA..4'hF no key
//   i_alarm_button   level, synchronous to clk
//   i_time_button    level, synchronous to clk
//   o_new_ms_hr/o_new_ls_hr/o_new_ms_min/o_new_ls_min   key buffer
//   o_load_new_c     one-cycle load strobe to the time counter
//   o_load_new_a     one-cycle load strobe to the alarm register
//   o_show_new_time  display shows the key buffer
//   o_show_a         display shows the alarm time
//   o_shift          a key is being captured this cycle
//   o_key_error      one-cycle strobe, entered time rejected
//   o_state          current FSM state (debug)
// -----------------------------------------------------------------------------
module aclk_controller #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_one_second,
  input  logic [3:0] i_key,
  input  logic       i_alarm_button,
  input  logic       i_time_button,
  output logic [3:0] o_new_ms_hr,
  output logic [3:0] o_new_ls_hr,
  output logic [3:0] o_new_ms_min,
  output logic [3:0] o_new_ls_min,
  output logic       o_load_new_c,
  output logic       o_load_new_a,
  output logic       o_show_new_time,
  output logic       o_show_a,
  output logic       o_shift,
  output logic       o_key_error,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_tcnt;
  logic [3:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic       w_digit, w_timeout, w_buf_first, w_buf_shift;

  assign w_digit   = (i_key <= 4'd9);
  assign w_timeout = i_one_second && (r_tcnt == 4'(TIMEOUT_SEC - 1));

`ifdef ACLK_KEY_VALIDATE_EN
  logic w_invalid, w_key_err, r_key_error;
  assign w_invalid = (r_ms_hr > 4'd2) ||
                     ((r_ms_hr == 4'd2) && (r_ls_hr > 4'd3)) ||
                     (r_ms_min > 4'd5);
`endif

  // Next-state logic. Buffer updates are flagged on the transition into
  // KEY_STORED so that the captured key is the one sampled at that edge.
  always_comb begin
    w_next      = r_state;
    w_buf_first = 1'b0;
    w_buf_shift = 1'b0;
`ifdef ACLK_KEY_VALIDATE_EN
    w_key_err   = 1'b0;
`endif
    case (r_state)
      SHOW_TIME: begin
        // time_button is ignored here so a held button cannot reload.
        if (i_alarm_button) w_next = SHOW_ALARM;
        else if (w_digit) begin
          w_next      = KEY_STORED;
          w_buf_first = 1'b1;
        end
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!w_digit)       w_next = KEY_ENTRY;
        else if (w_timeout) w_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
`ifdef ACLK_KEY_VALIDATE_EN
        if ((i_alarm_button || i_time_button) && w_invalid) begin
          w_next    = SHOW_TIME;
          w_key_err = 1'b1;
        end else
`endif
        if (i_alarm_button)     w_next = SET_ALARM_TIME;
        else if (i_time_button) w_next = SET_CURRENT_TIME;
        else if (w_timeout)     w_next = SHOW_TIME;
        else if (w_digit) begin
          w_next      = KEY_STORED;
          w_buf_shift = 1'b1;
        end
      end
      SHOW_ALARM:       if (!i_alarm_button) w_next = SHOW_TIME;
      SET_ALARM_TIME:   w_next = SHOW_TIME;
      SET_CURRENT_TIME: w_next = SHOW_TIME;
      default:          w_next = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SHOW_TIME;
    else       r_state <= w_next;
  end

  // Inactivity counter. It runs only while the FSM stays in the waiting
  // states and saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tcnt <= 4'd0;
    else if (!(w_next == KEY_WAITED || w_next == KEY_ENTRY)) r_tcnt <= 4'd0;
    else if (i_one_second && (r_state == KEY_WAITED || r_state == KEY_ENTRY)
             && (r_tcnt != 4'hF))
      r_tcnt <= r_tcnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_hr  <= 4'd0;
      r_ls_hr  <= 4'd0;
      r_ms_min <= 4'd0;
      r_ls_min <= 4'd0;
    end else if (w_buf_first) begin
      r_ms_hr  <= 4'd0;
      r_ls_hr  <= 4'd0;
      r_ms_min <= 4'd0;
      r_ls_min <= i_key;
    end else if (w_buf_shift) begin
      r_ms_hr  <= r_ls_hr;
      r_ls_hr  <= r_ms_min;
      r_ms_min <= r_ls_min;
      r_ls_min <= i_key;
    end
  end

`ifdef ACLK_KEY_VALIDATE_EN
  // Registered so the error strobe lines up with the cycle a load would use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_key_error <= 1'b0;
    else       r_key_error <= w_key_err;
  end
  assign o_key_error = r_key_error;
`else
  assign o_key_error = 1'b0;
`endif

  assign o_new_ms_hr     = r_ms_hr;
  assign o_new_ls_hr     = r_ls_hr;
  assign o_new_ms_min    = r_ms_min;
  assign o_new_ls_min    = r_ls_min;
  assign o_shift         = (r_state == KEY_STORED);
  assign o_show_new_time = (r_state == KEY_STORED) || (r_state == KEY_WAITED) ||
                           (r_state == KEY_ENTRY);
  assign o_show_a        = (r_state == SHOW_ALARM);
  assign o_load_new_a    = (r_state == SET_ALARM_TIME);
  assign o_load_new_c    = (r_state == SET_CURRENT_TIME);
  assign o_state         = r_state;

endmodule

// File: tb/tb_aclk_controller.sv
// -----------------------------------------------------------------------------
// tb_aclk_controller
//   Directed bench for aclk_controller. Expected load or error strobes
//   (kind + buffer value) are pushed to exp_q when the button is driven. A
//   negedge monitor pops them when the DUT raises a strobe.
//   Kind encoding: 3'b001 load_new_c, 3'b010 load_new_a, 3'b100 key_error.
// -----------------------------------------------------------------------------
module tb_aclk_controller;

  localparam logic [3:0] NOKEY = 4'hA;
  localparam logic [2:0] S_SHOW_TIME   = 3'd0;
  localparam logic [2:0] S_KEY_STORED  = 3'd1;
  localparam logic [2:0] S_KEY_WAITED  = 3'd2;
  localparam logic [2:0] S_KEY_ENTRY   = 3'd3;
  localparam logic [2:0] S_SHOW_ALARM  = 3'd4;
  localparam logic [2:0] S_SET_ALARM   = 3'd5;
  localparam logic [2:0] S_SET_CURRENT = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_one_second;
  logic [3:0] i_key;
  logic       i_alarm_button, i_time_button;
  logic [3:0] o_new_ms_hr, o_new_ls_hr, o_new_ms_min, o_new_ls_min;
  logic       o_load_new_c, o_load_new_a, o_show_new_time, o_show_a;
  logic       o_shift, o_key_error;
  logic [2:0] o_state;

  logic [18:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  aclk_controller #(.TIMEOUT_SEC(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_one_second   (i_one_second),
    .i_key          (i_key),
    .i_alarm_button (i_alarm_button),
    .i_time_button  (i_time_button),
    .o_new_ms_hr    (o_new_ms_hr),
    .o_new_ls_hr    (o_new_ls_hr),
    .o_new_ms_min   (o_new_ms_min),
    .o_new_ls_min   (o_new_ls_min),
    .o_load_new_c   (o_load_new_c),
    .o_load_new_a   (o_load_new_a),
    .o_show_new_time(o_show_new_time),
    .o_show_a       (o_show_a),
    .o_shift        (o_shift),
    .o_key_error    (o_key_error),
    .o_state        (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [15:0] w_buf;
  assign w_buf = {o_new_ms_hr, o_new_ls_hr, o_new_ms_min, o_new_ls_min};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && (o_load_new_c || o_load_new_a || o_key_error)) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {13'd0, o_key_error, o_load_new_a, o_load_new_c, w_buf}, 32'd0);
      else check("strobe", {13'd0, o_key_error, o_load_new_a, o_load_new_c, w_buf}, {13'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] k);
    i_key = k;
    tick();
    check("shift_on_key", {31'd0, o_shift}, 32'd1);
    i_key = NOKEY;
    tick();
    tick();
    check("state_key_entry", {29'd0, o_state}, {29'd0, S_KEY_ENTRY});
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_one_second = 1'b0; i_key = NOKEY;
    i_alarm_button = 1'b0; i_time_button = 1'b0;
    tick(); tick();
    check("reset_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    check("reset_buf", {16'd0, w_buf}, 32'd0);
    check("reset_outs", {26'd0, o_load_new_c, o_load_new_a, o_show_new_time, o_show_a, o_shift, o_key_error}, 32'd0);
    reset = 1'b0;
    tick();

    // 1,2,3,4 then time_button held for three cycles: exactly one load
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    check("buf_1234", {16'd0, w_buf}, 32'h1234);
    check("show_new_time_entry", {31'd0, o_show_new_time}, 32'd1);
    exp_q.push_back({3'b001, 16'h1234});
    i_time_button = 1'b1;
    tick();
    check("load_c_latency", {31'd0, o_load_new_c}, 32'd1);
    check("state_set_current", {29'd0, o_state}, {29'd0, S_SET_CURRENT});
    tick();
    check("state_after_set", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    tick();
    check("held_time_ignored", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    i_time_button = 1'b0;
    wait_drain();
    check("buf_hold_1234", {16'd0, w_buf}, 32'h1234);

    // 0,7,3,0 then alarm_button
    press_key(4'd0); press_key(4'd7); press_key(4'd3); press_key(4'd0);
    check("buf_0730", {16'd0, w_buf}, 32'h0730);
    exp_q.push_back({3'b010, 16'h0730});
    i_alarm_button = 1'b1;
    tick();
    check("load_a", {30'd0, o_load_new_a, o_load_new_c}, 32'd2);
    i_alarm_button = 1'b0;
    tick();
    check("state_after_alarm_set", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    wait_drain();

    // key 5 then idle: abandoned on the 10th one_second pulse
    press_key(4'd5);
    for (int i = 0; i < 9; i++) begin
      i_one_second = 1'b1; tick();
      i_one_second = 1'b0; tick();
    end
    check("no_timeout_after_9", {29'd0, o_state}, {29'd0, S_KEY_ENTRY});
    i_one_second = 1'b1; tick();
    i_one_second = 1'b0;
    check("timeout_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    check("timeout_show_new_time", {31'd0, o_show_new_time}, 32'd0);
    check("timeout_buf_hold", {16'd0, w_buf}, 32'h0005);
    tick();

    // alarm_button held 5 cycles in SHOW_TIME
    i_alarm_button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("show_a_held", {28'd0, o_show_a, o_state}, {28'd1, S_SHOW_ALARM});
    end
    i_alarm_button = 1'b0;
    tick();
    check("show_a_release", {28'd0, o_show_a, o_state}, {28'd0, S_SHOW_TIME});

    // five keys: oldest digit discarded
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4); press_key(4'd5);
    check("buf_2345", {16'd0, w_buf}, 32'h2345);
    exp_q.push_back({3'b001, 16'h2345});
    i_time_button = 1'b1; tick();
    i_time_button = 1'b0; tick();
    wait_drain();

    // 29:00 entered
    press_key(4'd2); press_key(4'd9); press_key(4'd0); press_key(4'd0);
`ifdef ACLK_KEY_VALIDATE_EN
    exp_q.push_back({3'b100, 16'h2900});
    i_time_button = 1'b1; tick();
    check("invalid_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
`else
    exp_q.push_back({3'b001, 16'h2900});
    i_time_button = 1'b1; tick();
    check("unvalidated_state", {29'd0, o_state}, {29'd0, S_SET_CURRENT});
`endif
    i_time_button = 1'b0; tick();
    check("after_2900_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    wait_drain();
    check("buf_hold_2900", {16'd0, w_buf}, 32'h2900);

    // asynchronous reset while in KEY_WAITED
    i_key = 4'd8; tick();
    i_key = NOKEY; tick();
    check("state_key_waited", {29'd0, o_state}, {29'd0, S_KEY_WAITED});
    #2 reset = 1'b1;
    #1;
    check("async_reset_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    check("async_reset_buf", {16'd0, w_buf}, 32'd0);
    check("async_reset_outs", {26'd0, o_load_new_c, o_load_new_a, o_show_new_time, o_show_a, o_shift, o_key_error}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("post_reset_state", {29'd0, o_state}, {29'd0, S_SHOW_TIME});
    check("scoreboard_empty_end", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aclk_controller.md
ACLK_CONTROLLER -- requirements
Module: aclk_controller

Interface
REQ-001 Parameter: TIMEOUT_SEC, 10, one_second pulses of key inactivity before key entry is abandoned (legal range 2..15).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: one_second  input  1  single-cycle pulse, once per second.
REQ-005 Port: key  input  4  keypad code; 0..9 digit, 4'hA NOKEY, 4'hB..4'hF treated as NOKEY.
REQ-006 Port: alarm_button, time_button  input  1 each  level-sensitive, synchronous to clk.
REQ-007 Port: new_ms_hr, new_ls_hr, new_ms_min, new_ls_min  output  4 each  key buffer (hour tens, hour units, minute tens, minute units) driving the time counter's and alarm register's load data.
REQ-008 Port: load_new_c, load_new_a  output  1 each  one-cycle load strobes to the time counter and alarm register.
REQ-009 Port: show_new_time, show_a, shift  output  1 each  display select and key-capture indicators.
REQ-010 Port: key_error  output  1  one-cycle strobe, invalid time rejected.

Function
REQ-011 FSM states SHALL be: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
REQ-012 SHOW_TIME: alarm_button -> SHOW_ALARM; else digit key -> KEY_STORED; else stay.
REQ-013 KEY_STORED -> KEY_WAITED unconditionally after one cycle.
REQ-014 KEY_WAITED: key NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay.
REQ-015 KEY_ENTRY priority: alarm_button -> SET_ALARM_TIME; time_button -> SET_CURRENT_TIME; timeout -> SHOW_TIME; digit key -> KEY_STORED; else stay.
REQ-016 SHOW_ALARM: alarm_button low -> SHOW_TIME; else stay.
REQ-017 SET_ALARM_TIME, SET_CURRENT_TIME -> SHOW_TIME after one cycle.
REQ-018 Outputs SHALL be Moore-decoded from state: shift in KEY_STORED; show_new_time in KEY_STORED/KEY_WAITED/KEY_ENTRY; show_a in SHOW_ALARM; load_new_a in SET_ALARM_TIME; load_new_c in SET_CURRENT_TIME; each otherwise 0.
REQ-019 Key buffer, on the edge entering KEY_STORED from SHOW_TIME: {ms_hr,ls_hr,ms_min,ls_min} <= {0,0,0,key}.
REQ-020 Key buffer, on the edge entering KEY_STORED from KEY_ENTRY: shift left one digit, key into new_ls_min, new_ms_hr discarded.
REQ-021 Key buffer SHALL hold its value in all other cycles, including through SET_* and SHOW_TIME.
REQ-022 Timeout counter (4 bit) SHALL clear on any edge where next state is not KEY_WAITED/KEY_ENTRY or state enters KEY_STORED; increment on one_second while in KEY_WAITED/KEY_ENTRY.
REQ-023 Timeout SHALL be true when counter == TIMEOUT_SEC-1 and one_second high; counter never wraps.
REQ-024 Button held across SET_* return SHALL NOT retrigger a load: SHOW_TIME ignores time_button; alarm_button re-entry goes to SHOW_ALARM only.
REQ-025 Loads SHALL occur exactly one cycle after the qualifying button sample (latency 1).

Reset
REQ-026 reset SHALL asynchronously force state SHOW_TIME, timeout counter 0, key buffer all 0.
REQ-027 During/after reset all strobes and show outputs SHALL be 0; reset mid-entry discards the buffer with no load.

Configuration
REQ-028 Macro ACLK_KEY_VALIDATE_EN defined: in KEY_ENTRY with alarm_button or time_button, if buffer invalid (ms_hr>2; ms_hr==2 and ls_hr>3; ms_min>5) FSM SHALL go to SHOW_TIME with key_error high one cycle and no load strobe.
REQ-029 Macro undefined: no validation, buffer loaded unconditionally, key_error tied 0.

Verification
REQ-030 Keys 1,2,3,4 (NOKEY between), then time_button -> one load_new_c pulse, buffer 1,2,3,4.
REQ-031 Keys 0,7,3,0, alarm_button -> load_new_a one cycle, load_new_c 0, then SHOW_TIME.
REQ-032 Key 5 then 10 one_second pulses idle -> SHOW_TIME, no load, show_new_time low.
REQ-033 alarm_button held 5 cycles in SHOW_TIME -> show_a high cycles 2..6, low after release.
REQ-034 Keys 1,2,3,4,5 then time_button -> buffer 2,3,4,5 loaded; keys 2,9,0,0 with macro -> key_error, no load.
REQ-035 reset asserted in KEY_WAITED -> immediate SHOW_TIME, buffer 0, no strobes.
